// File: rtl/gshare_predictor_ctrl_pkg.sv
// Predictor types shared by the gshare controller and its history register.
package gshare_predictor_ctrl_pkg;
    localparam int TBL_IDX_W = 5;
    localparam int TBL_CTR_W = 2;
    localparam int TBL_GHR_W = 5;

    typedef logic [TBL_IDX_W-1:0] idx_t;
    typedef logic [TBL_CTR_W-1:0] ctr_t;
    typedef logic [TBL_GHR_W-1:0] ghr_t;

    localparam ctr_t CTR_MAX = '1;
    localparam ctr_t CTR_MIN = '0;

    function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
        ctr_t res;
        res = ctr;
        if (taken && (ctr != CTR_MAX)) begin
            res = ctr + ctr_t'(1);
        end else if (!taken && (ctr != CTR_MIN)) begin
            res = ctr - ctr_t'(1);
        end
        return res;
    endfunction
endpackage

// File: rtl/gshare_predictor_ctrl_hist_reg.sv
// Speculative global history register: a commit-side restore beats a fetch-side shift.
module gshare_hist_reg
    import gshare_predictor_ctrl_pkg::*;
#(
    parameter int GHR_W = TBL_GHR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restore,
    input  logic [GHR_W-1:0] restore_ghr,
    input  logic             shift,
    input  logic             shift_bit,
    output logic [GHR_W-1:0] ghr
);
    logic [GHR_W-1:0] ghr_next;

    always_comb begin
        ghr_next = ghr;
        if (restore) begin
            ghr_next = restore_ghr;
        end else if (shift) begin
            ghr_next = {ghr[GHR_W-2:0], shift_bit};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr <= '0;
        end else begin
            ghr <= ghr_next;
        end
    end
endmodule

// File: rtl/gshare_predictor_ctrl.sv
// Gshare predictor controller: indexes the external counter table, returns a
// prediction one cycle after a request and applies commit-time counter updates.
module gshare_predictor_ctrl
    import gshare_predictor_ctrl_pkg::*;
#(
    parameter int IDX_W = TBL_IDX_W,
    parameter int CTR_W = TBL_CTR_W,
    parameter int GHR_W = TBL_GHR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_req,
    input  logic [31:0]      pred_pc,
    input  logic             pred_stall,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [CTR_W-1:0] pred_ctr,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             pred_shift,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic [CTR_W-1:0] upd_ctr,
    input  logic             upd_taken,
    input  logic             upd_mispredict,
    output logic             tbl_we,
    output logic [IDX_W-1:0] tbl_wr_addr,
    output logic [CTR_W-1:0] tbl_data_in,
    output logic [IDX_W-1:0] tbl_rd_addr,
    input  logic [CTR_W-1:0] tbl_data_out
);
    function automatic logic [IDX_W-1:0] idx_of(input logic [IDX_W-1:0] pc_bits,
                                                input logic [GHR_W-1:0] hist);
        return pc_bits ^ IDX_W'(hist);
    endfunction

    logic [GHR_W-1:0] ghr;
    logic             hold_p1;
    logic             kill;
    logic [IDX_W-1:0] rd_idx_p0;
    logic             fwd_hit_p0;
    logic             vld_p1;
    logic             fwd_hit_p1;
    logic [CTR_W-1:0] fwd_ctr_p1;
    logic [GHR_W-1:0] ghr_p1;
    logic [IDX_W-1:0] idx_p1;
    logic [CTR_W-1:0] ctr_p1;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0],
                              upd_pc[31:IDX_W+2], upd_pc[1:0]};

    assign hold_p1 = vld_p1 & pred_stall;
    assign kill    = upd_valid & upd_mispredict;

    // p0: lookup; a held response keeps re-reading its own index so table data stays coherent
    assign rd_idx_p0   = hold_p1 ? idx_p1 : idx_of(pred_pc[IDX_W+1:2], ghr);
    assign tbl_rd_addr = rd_idx_p0;

    assign tbl_we      = upd_valid & rst;
    assign tbl_wr_addr = idx_of(upd_pc[IDX_W+1:2], upd_ghr);
    assign tbl_data_in = CTR_W'(sat_update(ctr_t'(upd_ctr), upd_taken));
    assign fwd_hit_p0  = tbl_we & (tbl_wr_addr == rd_idx_p0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1     <= 1'b0;
            fwd_hit_p1 <= 1'b0;
        end else begin
            if (kill) begin
                vld_p1 <= 1'b0;
            end else if (!hold_p1) begin
                vld_p1 <= pred_req;
            end
            if (!hold_p1) begin
                fwd_hit_p1 <= fwd_hit_p0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!hold_p1) begin
            ghr_p1     <= ghr;
            idx_p1     <= rd_idx_p0;
            fwd_ctr_p1 <= tbl_data_in;
        end
    end

    // p1: response
    assign ctr_p1     = fwd_hit_p1 ? fwd_ctr_p1 : tbl_data_out;
    assign pred_valid = vld_p1;
    assign pred_ctr   = vld_p1 ? ctr_p1 : '0;
    assign pred_taken = pred_ctr[CTR_W-1];
    assign pred_ghr   = vld_p1 ? ghr_p1 : '0;

    gshare_hist_reg #(
        .GHR_W(GHR_W)
    ) u_hist (
        .clk        (clk),
        .rst        (rst),
        .restore    (kill),
        .restore_ghr({upd_ghr[GHR_W-2:0], upd_taken}),
        .shift      (vld_p1 & ~pred_stall & pred_shift),
        .shift_bit  (pred_taken),
        .ghr        (ghr)
    );
endmodule

// File: tb/tb_gshare_predictor_ctrl.sv
// Scoreboard bench for gshare_predictor_ctrl with a behavioural table and reference model.
module tb_gshare_predictor_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pred_req = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        pred_stall = 1'b0;
    logic        pred_valid;
    logic        pred_taken;
    logic [1:0]  pred_ctr;
    logic [4:0]  pred_ghr;
    logic        pred_shift = 1'b0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [4:0]  upd_ghr = '0;
    logic [1:0]  upd_ctr = '0;
    logic        upd_taken = 1'b0;
    logic        upd_mispredict = 1'b0;
    logic        tbl_we;
    logic [4:0]  tbl_wr_addr;
    logic [1:0]  tbl_data_in;
    logic [4:0]  tbl_rd_addr;
    logic [1:0]  tbl_data_out;

    always #5 clk = ~clk;

    gshare_predictor_ctrl dut (
        .clk(clk), .rst(rst),
        .pred_req(pred_req), .pred_pc(pred_pc), .pred_stall(pred_stall),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ctr(pred_ctr),
        .pred_ghr(pred_ghr), .pred_shift(pred_shift),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_ctr(upd_ctr),
        .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
        .tbl_we(tbl_we), .tbl_wr_addr(tbl_wr_addr), .tbl_data_in(tbl_data_in),
        .tbl_rd_addr(tbl_rd_addr), .tbl_data_out(tbl_data_out)
    );

    // External counter table: registered read-first port, synchronous active-high reset from ~rst.
    logic [1:0] mem [32];
    logic [1:0] tbl_q;
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= 2'd0;
            tbl_q <= 2'd0;
        end else begin
            if (tbl_we) mem[tbl_wr_addr] <= tbl_data_in;
            tbl_q <= mem[tbl_rd_addr];
        end
    end
    assign tbl_data_out = tbl_q;

    int tests = 0;
    int fails = 0;

    function automatic void check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Reference model
    typedef struct { int ctr; int ghr; } resp_t;
    typedef struct { int addr; int data; } wr_t;
    resp_t resp_q[$];
    wr_t   wr_q[$];
    int    rd_q[$];
    int    tbl_m[32];
    int    ghr_m;
    bit    pend;
    int    pend_ctr;
    bit    kill_pend;

    function automatic int idx_m(logic [31:0] pc, int h);
        return (int'(pc >> 2) ^ h) & 31;
    endfunction

    function automatic int sat_m(int c, bit t);
        if (t) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    function automatic void model_reset();
        ghr_m = 0; pend = 0; pend_ctr = 0; kill_pend = 0;
        resp_q.delete(); wr_q.delete(); rd_q.delete();
        foreach (tbl_m[i]) tbl_m[i] = 0;
    endfunction

    task automatic step(input bit req, input logic [31:0] pc, input bit stall, input bit shift,
                        input bit uv, input logic [31:0] upc, input int ughr, input int uctr,
                        input bit utaken, input bit umis);
        bit was_pend, hold, mis;
        int taken_m, idx, a;
        @(negedge clk);
        if (kill_pend) begin
            void'(resp_q.pop_front());
            kill_pend = 0;
        end
        pred_req = req; pred_pc = pc; pred_stall = stall; pred_shift = shift;
        upd_valid = uv; upd_pc = upc; upd_ghr = ughr[4:0]; upd_ctr = uctr[1:0];
        upd_taken = utaken; upd_mispredict = umis;
        was_pend = pend;
        hold = pend && stall;
        mis = uv && umis;
        taken_m = (pend_ctr >= 2) ? 1 : 0;
        if (uv) begin
            a = idx_m(upc, ughr);
            tbl_m[a] = sat_m(uctr, utaken);
            wr_q.push_back('{a, tbl_m[a]});
        end
        idx = idx_m(pc, ghr_m);
        if (req && !hold) rd_q.push_back(idx);
        if (mis) begin
            if (hold) kill_pend = 1;
            pend = 0;
        end else if (!hold) begin
            pend = req;
            if (req) begin
                pend_ctr = tbl_m[idx];
                resp_q.push_back('{pend_ctr, ghr_m});
            end
        end
        if (mis) ghr_m = ((ughr << 1) | int'(utaken)) & 31;
        else if (was_pend && !stall && shift) ghr_m = ((ghr_m << 1) | taken_m) & 31;
    endtask

    task automatic idle();
        step(0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = $urandom;
        if ($urandom_range(0, 3) != 0) p[6:2] = 5'($urandom_range(0, 3));
        return p;
    endfunction

    // Monitor: compares whatever the DUT presents against the queued expectations.
    resp_t mon_e;
    always @(negedge clk) begin
        #1;
        if (rst) begin
            if (pred_req && !(pred_valid && pred_stall)) begin
                if (rd_q.size() == 0) check("rd_addr_unexpected_lookup", 1, 0);
                else check("tbl_rd_addr", int'(tbl_rd_addr), rd_q.pop_front());
            end
            if (tbl_we) begin
                if (wr_q.size() == 0) check("tbl_we_spurious", 1, 0);
                else begin
                    check("tbl_wr_addr", int'(tbl_wr_addr), wr_q[0].addr);
                    check("tbl_data_in", int'(tbl_data_in), wr_q[0].data);
                    void'(wr_q.pop_front());
                end
            end
            if (pred_valid) begin
                if (resp_q.size() == 0) check("pred_valid_spurious", 1, 0);
                else begin
                    mon_e = resp_q[0];
                    check("pred_ctr", int'(pred_ctr), mon_e.ctr);
                    check("pred_taken", int'(pred_taken), (mon_e.ctr >= 2) ? 1 : 0);
                    check("pred_ghr", int'(pred_ghr), mon_e.ghr);
                    if (!pred_stall) void'(resp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        bit r_stall, r_req, r_uv;
        int r_ghr;
        model_reset();
        upd_valid = 1'b1;
        upd_pc = 32'h10;
        repeat (3) @(negedge clk);
        #2;
        check("reset_pred_valid", int'(pred_valid), 0);
        check("reset_pred_ctr", int'(pred_ctr), 0);
        check("reset_pred_taken", int'(pred_taken), 0);
        check("reset_pred_ghr", int'(pred_ghr), 0);
        check("reset_tbl_we", int'(tbl_we), 0);
        upd_valid = 1'b0;
        rst = 1'b1;

        // Basic lookup
        step(1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0); #2;
        check("t1_rd_addr", int'(tbl_rd_addr), 4);
        idle(); #2;
        check("t1_valid", int'(pred_valid), 1);
        check("t1_ctr", int'(pred_ctr), 0);
        check("t1_taken", int'(pred_taken), 0);
        check("t1_ghr", int'(pred_ghr), 0);

        // Saturating updates
        step(0, 0, 0, 0, 1, 32'h10, 0, 1, 1, 0); #2;
        check("t2_we", int'(tbl_we), 1);
        check("t2_addr", int'(tbl_wr_addr), 4);
        check("t2_data", int'(tbl_data_in), 2);
        step(1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(); #2;
        check("t2_ctr", int'(pred_ctr), 2);
        check("t2_taken", int'(pred_taken), 1);
        step(0, 0, 0, 0, 1, 32'h10, 0, 3, 1, 0); #2;
        check("t2_sat_hi", int'(tbl_data_in), 3);
        step(0, 0, 0, 0, 1, 32'h10, 0, 0, 0, 0); #2;
        check("t2_sat_lo", int'(tbl_data_in), 0);

        // Same-cycle write forwarding
        step(1, 32'h10, 0, 0, 1, 32'h10, 0, 1, 1, 0);
        idle(); #2;
        check("t3_fwd_ctr", int'(pred_ctr), 2);

        // Three taken shifts build GHR = 0b00111
        step(0, 0, 0, 0, 1, 32'h14, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 32'h1c, 0, 1, 1, 0);
        repeat (3) begin
            step(1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0);
            step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0); #2;
            check("t4_taken", int'(pred_taken), 1);
        end
        step(1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0); #2;
        check("t4_rd_addr", int'(tbl_rd_addr), 3);

        // Mispredict kills a stalled response and restores history
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 1, 32'h10, 3, 2, 0, 1);
        idle(); #2;
        check("t5_killed_valid", int'(pred_valid), 0);
        step(1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0); #2;
        check("t5_ghr_rd_addr", int'(tbl_rd_addr), 2);
        step(1, 32'h10, 0, 0, 1, 32'h10, 6, 1, 1, 1);
        idle(); #2;
        check("t5_drop_valid", int'(pred_valid), 0);

        // Asynchronous reset in the middle of a stall
        step(1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 32'h10, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #3 rst = 1'b0;
        #1;
        check("t6_async_valid", int'(pred_valid), 0);
        check("t6_async_rd_addr", int'(tbl_rd_addr), 4);
        check("t6_async_ctr", int'(pred_ctr), 0);
        model_reset();
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        step(1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0); #2;
        check("t6_rd_addr", int'(tbl_rd_addr), 4);
        idle(); #2;
        check("t6_valid", int'(pred_valid), 1);
        check("t6_ctr", int'(pred_ctr), 0);

        // Randomized traffic; table writes only in cycles where fetch is not stalling
        for (int n = 0; n < 2000; n++) begin
            r_stall = ($urandom_range(0, 3) == 0);
            r_req   = r_stall ? 1'b0 : 1'($urandom_range(0, 1));
            r_uv    = r_stall ? 1'b0 : ($urandom_range(0, 2) == 0);
            r_ghr   = ($urandom_range(0, 1) == 1) ? ghr_m : int'($urandom_range(0, 31));
            step(r_req, rand_pc(), r_stall, 1'($urandom_range(0, 1)),
                 r_uv, rand_pc(), r_ghr, int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end
        repeat (3) idle();
        #2;
        check("drain_resp_q", resp_q.size(), 0);
        check("drain_wr_q", wr_q.size(), 0);
        check("drain_rd_q", rd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gshare_predictor_ctrl.md
Name: gshare_predictor_ctrl

Overview:
Controller that reads and writes the predictor counter table. It drives the table's read address, write enable, write address and write data, and consumes the table's registered read data. On the fetch side it forms a gshare index, returns a 2-bit-counter prediction one cycle later, and keeps a speculative global history register (GHR). On the commit side it applies saturating counter updates and restores history after a mispredict.

Parameters:
IDX_W, 5, table index width; the table depth is 2**IDX_W.
CTR_W, 2, counter width; must equal the table data width.
GHR_W, 5, global history length; must be at most IDX_W.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
pred_req  in  1  fetch requests a prediction this cycle
pred_pc  in  32  fetch PC
pred_stall  in  1  fetch cannot accept the response; hold it
pred_valid  out  1  response valid
pred_taken  out  1  predicted direction, equal to MSB of the counter
pred_ctr  out  CTR_W  counter value; carried down the pipeline to commit
pred_ghr  out  GHR_W  GHR snapshot used for the index; carried to commit
pred_shift  in  1  fetch confirms the responded instruction is a branch; shift the GHR
upd_valid  in  1  commit-time branch resolution
upd_pc  in  32  PC of the resolved branch
upd_ghr  in  GHR_W  snapshot carried with the branch
upd_ctr  in  CTR_W  counter value carried with the branch
upd_taken  in  1  actual direction
upd_mispredict  in  1  actual direction differs from the prediction
tbl_we  out  1  table write enable
tbl_wr_addr  out  IDX_W  table write address
tbl_data_in  out  CTR_W  table write data
tbl_rd_addr  out  IDX_W  table read address
tbl_data_out  in  CTR_W  table read data, registered; valid one cycle after tbl_rd_addr

Behaviour:
- Index function: idx(pc, h) = pc[IDX_W+1:2] XOR zero-extended h.
- Reset (rst = 0, asynchronous):
  - GHR = 0, pred_valid = 0, forwarding register cleared, tbl_we = 0.
  - pred_taken, pred_ctr and pred_ghr read 0.
  - The table's own active-high synchronous reset is driven from ~rst at the top level. Counters reset to 0 (strongly not-taken).
- Lookup stage (cycle N, pred_req = 1, pred_stall = 0):
  - tbl_rd_addr = idx(pred_pc, GHR).
  - The stage registers the snapshot GHR and sets pred_valid = 1 for cycle N+1.
  - If pred_req = 0, pred_valid = 0 in cycle N+1.
- Response (cycle N+1):
  - pred_ctr = forwarded value if the forwarding register hit, otherwise tbl_data_out.
  - pred_taken = pred_ctr[CTR_W-1].
  - pred_ghr = the registered snapshot.
- Stall: while pred_stall = 1 and pred_valid = 1, the response registers hold. tbl_rd_addr re-presents the held index so tbl_data_out remains coherent. New requests are ignored.
- Update (upd_valid = 1, combinational write in the same cycle):
  - tbl_we = 1, tbl_wr_addr = idx(upd_pc, upd_ghr).
  - tbl_data_in = upd_ctr + 1 if taken, upd_ctr - 1 if not taken, saturating at 0 and 2**CTR_W - 1.
  - No read-modify-write is performed; the table read port is never used for updates.
- Forwarding:
  - If tbl_we = 1 and tbl_wr_addr == tbl_rd_addr in the same cycle, register hit = 1 and data = tbl_data_in.
  - The next response uses that data instead of the stale table output.
  - Writes landing during the response cycle are not forwarded.
- GHR update priority, highest first:
  1. upd_valid & upd_mispredict: GHR <= {upd_ghr[GHR_W-2:0], upd_taken}. The in-flight response is killed (pred_valid <= 0), including any stalled response.
  2. pred_valid & !pred_stall & pred_shift: GHR <= {GHR[GHR_W-2:0], pred_taken}.
  3. Otherwise GHR holds.
- Simultaneous mispredict and new pred_req: the request is dropped. Fetch is being redirected, so no response is produced in the next cycle.
- Wrap: index arithmetic is modulo 2**IDX_W; PC bits above IDX_W+1 are ignored.

Decomposition:
- Shared package (predictor types): ctr_t (CTR_W bits), ghr_t, idx_t, the constants CTR_MAX / CTR_MIN, and a pure function sat_update(ctr, taken).
- One natural sub-module: gshare_hist_reg, holding the GHR plus its restore/shift priority logic.
- The table itself stays external and instantiated alongside this block.

Test Plan:
1. After reset, request pc=0x0000_0010 -> cycle+1: pred_valid=1, pred_ctr=0, pred_taken=0, pred_ghr=0, tbl_rd_addr=4.
2. Update pc=0x10, ghr=0, ctr=1, taken=1 -> tbl_we=1, addr=4, data=2. Next request at pc=0x10 -> pred_ctr=2, taken=1. Update with ctr=3, taken=1 -> data=3 (saturates). Update with ctr=0, taken=0 -> data=0.
3. Same cycle: request pc=0x10 and update writing addr 4 with data=2 -> next response pred_ctr=2 (forwarded), not 0.
4. GHR=0 with three responses pred_taken=1 and pred_shift=1 -> GHR=0b00111. Next request pc=0x10 -> tbl_rd_addr = 4 XOR 7 = 3.
5. Mispredict with upd_ghr=0b00011, taken=0, while a response is pending and pred_stall=1 -> pred_valid=0 next cycle, GHR=0b00110. No speculative shift is applied that cycle.
6. rst asserted mid-stall -> pred_valid=0 and GHR=0 immediately, without waiting for a clock edge. After release, the first request behaves as in scenario 1.
